inst_sram_responder: RTL and testbench

//   Responder (slave) end of the inst/data SRAM port driven by the pipeline's fetch stage:

---
 rtl/inst_sram_responder.sv | 116 +++++++++++
 tb/tb_inst_sram_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_sram_responder.sv
// Responder end of the instruction/data SRAM port.
// Word-organised on-chip RAM mapped at BASE_ADDR, one-cycle read latency,
// write-first on a same-edge write, zero-clear sweep after reset and a
// one-cycle error pulse for accesses that fall outside the address window.
module inst_sram_responder #(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'hbfc00000,
  parameter bit          INIT_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sram_en,
  input  logic [3:0]  sram_wen,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic        sram_err,
  output logic        init_done
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam int                TAG_W    = 30 - ADDR_W;
  localparam logic [TAG_W-1:0]  BASE_TAG = BASE_ADDR[31:ADDR_W+2];
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  // Selects the RAM read register onto sram_rdata; cleared on a miss and in INIT
  // so the output reads zero without touching the RAM read path.
  logic              show_ram;
  logic [31:0]       ram_q;

  logic              hit;
  logic [ADDR_W-1:0] idx;
  logic              ram_access;
  logic              clear_en;
  logic [ADDR_W-1:0] wr_addr;
  // Byte offset bits are deliberately not decoded: accesses are word-wide.
  logic              unused_addr_bits;

  assign hit              = (sram_addr[31:ADDR_W+2] == BASE_TAG);
  assign idx              = sram_addr[ADDR_W+1:2];
  assign ram_access       = (state == S_RUN) && sram_en && hit;
  assign clear_en         = (state == S_INIT) && INIT_ZERO;
  assign wr_addr          = clear_en ? clr_cnt : idx;
  assign unused_addr_bits = ^sram_addr[1:0];

  // One byte-wide RAM per lane so each byte enable maps onto its own write port.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic       lane_we;
      logic [7:0] lane_wdata;
      logic [7:0] lane_q;

      assign lane_we    = clear_en || (ram_access && sram_wen[gi]);
      assign lane_wdata = clear_en ? 8'h00 : sram_wdata[8*gi +: 8];

      // Lane write port: zero sweep during INIT, masked byte writes in RUN.
      always_ff @(posedge clk) begin
        if (lane_we) begin
          mem[wr_addr] <= lane_wdata;
        end
      end

      // Registered lane read, write-first; holds its value when not accessed.
      always_ff @(posedge clk) begin
        if (ram_access) begin
          lane_q <= sram_wen[gi] ? sram_wdata[8*gi +: 8] : mem[idx];
        end
      end

      assign ram_q[8*gi +: 8] = lane_q;
    end
  endgenerate

  assign sram_rdata = show_ram ? ram_q : 32'h0;

  // Control FSM: clear sweep in INIT, then serve accesses and flag misses in RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_INIT;
      clr_cnt   <= '0;
      init_done <= 1'b0;
      sram_err  <= 1'b0;
      show_ram  <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          sram_err <= 1'b0;
          show_ram <= 1'b0;
          clr_cnt  <= clr_cnt + 1'b1;
          if (!INIT_ZERO || (clr_cnt == LAST_IDX)) begin
            state     <= S_RUN;
            init_done <= 1'b1;
          end
        end
        S_RUN: begin
          if (sram_en) begin
            show_ram <= hit;
            sram_err <= !hit;
          end else begin
            sram_err <= 1'b0;
          end
        end
        default: begin
          state <= S_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_sram_responder.sv
// Directed + randomised bench for inst_sram_responder (ADDR_W=4, 16 words).
// A behavioural model predicts rdata/err per request; predictions are queued
// when a request is driven and compared once the DUT has clocked it.
module tb_inst_sram_responder;

  localparam int          ADDR_W   = 4;
  localparam logic [31:0] BASE     = 32'hbfc00000;
  localparam logic [25:0] BASE_TAG = 26'h2ff0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_err;
  logic        init_done;

  always #5 clk = ~clk;

  inst_sram_responder #(
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE),
    .INIT_ZERO(1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sram_en   (sram_en),
    .sram_wen  (sram_wen),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata),
    .sram_err  (sram_err),
    .init_done (init_done)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_mem [16];
  logic [31:0] m_rdata;
  bit          m_run;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic bit m_hit(input logic [31:0] a);
    return a[31:6] == BASE_TAG;
  endfunction

  // Drive one request and push the model's prediction for the following cycle.
  task automatic drive(input logic en, input logic [3:0] wen,
                       input logic [31:0] addr, input logic [31:0] wdata);
    exp_t        e;
    logic [31:0] merged;
    int          i;
    sram_en    = en;
    sram_wen   = wen;
    sram_addr  = addr;
    sram_wdata = wdata;
    e.err = 1'b0;
    if (!m_run) begin
      m_rdata = 32'h0;
    end else if (en) begin
      if (m_hit(addr)) begin
        i      = int'(addr[5:2]);
        merged = m_mem[i];
        for (int b = 0; b < 4; b++) begin
          if (wen[b]) merged[8*b +: 8] = wdata[8*b +: 8];
        end
        m_mem[i] = merged;
        m_rdata  = merged;
      end else begin
        m_rdata = 32'h0;
        e.err   = 1'b1;
      end
    end
    e.rdata = m_rdata;
    sb_q.push_back(e);
  endtask

  // Clock the pending request and compare against the oldest prediction.
  task automatic step(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, " scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, " rdata"}, sram_rdata, e.rdata);
      chk({tag, " err"}, {31'b0, sram_err}, {31'b0, e.err});
    end
  endtask

  task automatic access(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input string tag);
    drive(en, wen, addr, wdata);
    step(tag);
  endtask

  // Run through INIT, optionally hammering word 1 with requests, and check its length.
  task automatic wait_init(input bit with_reqs, input string tag);
    int cnt = 0;
    while (1) begin
      if (with_reqs) drive(1'b1, (cnt % 2 == 1) ? 4'hf : 4'h0, 32'hbfc00004, 32'h5a5a5a5a);
      else           drive(1'b0, 4'h0, 32'h0, 32'h0);
      step({tag, " sweep"});
      cnt++;
      if (init_done === 1'b1 || cnt >= 100) break;
    end
    m_run = 1'b1;
    chk({tag, " cycles"}, 32'(cnt), 32'd16);
  endtask

  task automatic model_reset();
    m_run   = 1'b0;
    m_rdata = 32'h0;
    for (int i = 0; i < 16; i++) m_mem[i] = 32'h0;
  endtask

  initial begin
    reset = 1'b1;
    sram_en = 1'b0; sram_wen = 4'h0; sram_addr = 32'h0; sram_wdata = 32'h0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset rdata", sram_rdata, 32'h0);
    chk("reset err", {31'b0, sram_err}, 32'h0);
    chk("reset init_done", {31'b0, init_done}, 32'h0);
    reset = 1'b0;
    wait_init(1'b0, "init1");

    // Every word reads zero after the sweep
    for (int i = 0; i < 16; i++) access(1'b1, 4'h0, BASE + 32'(i * 4), 32'h0, "zero_rd");

    // Full write, write-first return, masked lane write
    access(1'b1, 4'hf, 32'hbfc00008, 32'h11223344, "wr_full");
    access(1'b1, 4'h0, 32'hbfc00008, 32'h0, "rd_full");
    access(1'b1, 4'h2, 32'hbfc00008, 32'h0000ab00, "wr_lane1");
    access(1'b1, 4'h0, 32'hbfc00008, 32'h0, "rd_lane1");
    chk("rd_lane1 literal", sram_rdata, 32'h1122ab44);

    // Hold while idle; an en=0 write must not land
    access(1'b1, 4'hf, 32'hbfc00000, 32'hcafef00d, "wr0");
    access(1'b1, 4'h0, 32'hbfc00008, 32'h0, "rd2");
    access(1'b1, 4'h0, 32'hbfc00000, 32'h0, "rd0");
    for (int i = 0; i < 5; i++) access(1'b0, 4'hf, 32'hbfc00000, 32'hffffffff, "hold");
    access(1'b1, 4'h0, 32'hbfc00000, 32'h0, "rd0_again");

    // Window misses, dropped write, unaligned address
    access(1'b1, 4'h0, 32'h80000000, 32'h0, "miss_rd");
    access(1'b0, 4'h0, 32'h0, 32'h0, "miss_after");
    access(1'b1, 4'hf, 32'h80000008, 32'hdeadbeef, "miss_wr");
    access(1'b1, 4'h0, 32'hbfc00008, 32'h0, "after_miss");
    access(1'b1, 4'h0, 32'hbfc0000b, 32'h0, "unaligned");

    // Randomised back-to-back traffic
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      logic [3:0]  w;
      a = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) a = 32'h80000000 | 32'($urandom_range(0, 255) * 4);
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      access(($urandom_range(0, 7) != 0), w, a, $urandom, "rand");
    end

    // Asynchronous reset in RUN: outputs drop before any clock edge
    access(1'b1, 4'hf, 32'hbfc0003c, 32'h89abcdef, "pre_rst");
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    sb_q.delete();
    #2 reset = 1'b1;
    #1;
    chk("async rdata", sram_rdata, 32'h0);
    chk("async err", {31'b0, sram_err}, 32'h0);
    chk("async init_done", {31'b0, init_done}, 32'h0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;

    // Reset again at sweep count 7; sweep must restart and run the full length
    repeat (7) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_sweep init_done", {31'b0, init_done}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    wait_init(1'b1, "init2");

    // Requests issued in INIT left no trace; old contents were cleared
    access(1'b1, 4'h0, 32'hbfc00004, 32'h0, "post_init_w1");
    access(1'b1, 4'h0, 32'hbfc0003c, 32'h0, "post_init_w15");
    chk("post_init_w15 literal", sram_rdata, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
